// File: rtl/bp_cfg_mmio_responder_if.sv
// ---------------------------------------------------------------------------
// bp_cfg_mmio_responder_if
//   Command/response channel between a cfg-network master (the loader) and a
//   tile-side cfg target.
//
//   Handshake rules:
//     Command  : valid->ready. The target raises io_cmd_ready only while it
//                can take a command. A command transfers on a cycle where
//                io_cmd_v && io_cmd_ready. The master holds io_cmd stable
//                while io_cmd_v is high and the command is not yet taken.
//     Response : valid->yumi. The target holds io_resp/io_resp_v stable until
//                the master pulses io_resp_yumi. io_resp_yumi may only be
//                high while io_resp_v is high.
//
//   Signals:
//     io_cmd        master->target  command message
//     io_cmd_v      master->target  command valid
//     io_cmd_ready  target->master  command accepted this cycle
//     io_resp       target->master  response message
//     io_resp_v     target->master  response valid
//     io_resp_yumi  master->target  response consumed
// ---------------------------------------------------------------------------
interface bp_cfg_mmio_responder_if
  #(parameter int msg_width_p = 112);

    logic [msg_width_p-1:0] io_cmd;
    logic                   io_cmd_v;
    logic                   io_cmd_ready;
    logic [msg_width_p-1:0] io_resp;
    logic                   io_resp_v;
    logic                   io_resp_yumi;

    modport master (
        output io_cmd, io_cmd_v, io_resp_yumi,
        input  io_cmd_ready, io_resp, io_resp_v
    );

    modport slave (
        input  io_cmd, io_cmd_v, io_resp_yumi,
        output io_cmd_ready, io_resp, io_resp_v
    );

endinterface

// File: rtl/bp_cfg_mmio_responder.sv
// ---------------------------------------------------------------------------
// bp_cfg_mmio_responder
//   Configuration-network target for one tile. Takes one command at a time
//   from the cfg network, decodes the local address, and either updates one
//   of the tile configuration registers (reset, freeze, I$/D$ LCE mode,
//   CCE mode, boot NPC) or drives the CCE microcode RAM port. Exactly one
//   response is returned per accepted command.
//
//   Message layout (MSB..LSB):
//     { msg_type[1:0], addr[paddr_width_p-1:0], size[1:0],
//       payload[lce_id_width_p-1:0], data[dword_width_p-1:0] }
//   msg_type: 0 = read (e_cce_io_rd), 1 = write (e_cce_io_wr).
//   Address layout (LSB upward):
//     addr  [cfg_addr_width_p-1:0]  register / ucode offset
//     dev   [3:0]                   device id, cfg device = 2
//     cce   [cce_id_width_p-1:0]    target CCE id
//     nonlocal [0]                  must be 0 for this tile
//   Bits above nonlocal are ignored by decode and echoed in the response.
//
//   Ports:
//     clk_i, reset_i        clock, synchronous active-high reset
//     cce_id_i              this tile's CCE id (static)
//     io                    cmd/resp channel (slave side)
//     reset_o, freeze_o     tile reset / freeze
//     icache_mode_o,
//     dcache_mode_o         LCE modes (0 = uncached)
//     cce_mode_o            CCE mode (0 = uncached)
//     npc_o, npc_w_v_o      boot PC and its one-cycle write pulse
//     cce_ucode_*           ucode RAM port; strobes are combinational in
//                           the accept cycle, read data returns next cycle
//     err_o                 sticky error (only with BP_CFG_MMIO_ERR_EN)
//     fsm_state_o           current FSM state (0 READY, 1 UCODE_RD, 2 RESP)
//
//   Build option:
//     BP_CFG_MMIO_ERR_EN  when defined, unmapped / unknown-offset / unknown
//                         type commands answer with all-ones data and set
//                         err_o. When undefined they answer with 0 and there
//                         is no err_o port.
// ---------------------------------------------------------------------------
module bp_cfg_mmio_responder
  #(parameter int paddr_width_p         = 40,
    parameter int dword_width_p         = 64,
    parameter int lce_id_width_p        = 4,
    parameter int cfg_addr_width_p      = 16,
    parameter int cce_id_width_p        = 4,
    parameter int vaddr_width_p         = 39,
    parameter int inst_ram_addr_width_p = 8,
    parameter int cce_inst_width_p      = 48)
   (input  logic                             clk_i,
    input  logic                             reset_i,
    input  logic [cce_id_width_p-1:0]        cce_id_i,
    bp_cfg_mmio_responder_if.slave           io,
    output logic                             reset_o,
    output logic                             freeze_o,
    output logic [1:0]                       icache_mode_o,
    output logic [1:0]                       dcache_mode_o,
    output logic                             cce_mode_o,
    output logic [vaddr_width_p-1:0]         npc_o,
    output logic                             npc_w_v_o,
    output logic                             cce_ucode_v_o,
    output logic                             cce_ucode_w_o,
    output logic [inst_ram_addr_width_p-1:0] cce_ucode_addr_o,
    output logic [cce_inst_width_p-1:0]      cce_ucode_data_o,
    input  logic [cce_inst_width_p-1:0]      cce_ucode_data_i,
`ifdef BP_CFG_MMIO_ERR_EN
    output logic                             err_o,
`endif
    output logic [1:0]                       fsm_state_o);

    // ---------------------------------------------------------------------
    // Message field positions
    // ---------------------------------------------------------------------
    localparam int dev_width_lp   = 4;
    localparam int data_lsb_lp    = 0;
    localparam int payload_lsb_lp = dword_width_p;
    localparam int size_lsb_lp    = payload_lsb_lp + lce_id_width_p;
    localparam int addr_lsb_lp    = size_lsb_lp + 2;
    localparam int type_lsb_lp    = addr_lsb_lp + paddr_width_p;
    localparam int msg_width_lp   = type_lsb_lp + 2;
    localparam int hdr_width_lp   = msg_width_lp - dword_width_p;

    localparam int dev_lsb_lp      = addr_lsb_lp + cfg_addr_width_p;
    localparam int cce_lsb_lp      = dev_lsb_lp + dev_width_lp;
    localparam int nonlocal_bit_lp = cce_lsb_lp + cce_id_width_p;

    // ---------------------------------------------------------------------
    // Address map
    // ---------------------------------------------------------------------
    localparam logic [1:0] e_cce_io_rd = 2'd0;
    localparam logic [1:0] e_cce_io_wr = 2'd1;

    localparam logic [dev_width_lp-1:0] cfg_dev_gp = 4'd2;

    localparam logic [cfg_addr_width_p-1:0] bp_cfg_reg_reset_gp        = cfg_addr_width_p'('h0001);
    localparam logic [cfg_addr_width_p-1:0] bp_cfg_reg_freeze_gp       = cfg_addr_width_p'('h0002);
    localparam logic [cfg_addr_width_p-1:0] bp_cfg_reg_npc_gp          = cfg_addr_width_p'('h0010);
    localparam logic [cfg_addr_width_p-1:0] bp_cfg_reg_icache_mode_gp  = cfg_addr_width_p'('h0022);
    localparam logic [cfg_addr_width_p-1:0] bp_cfg_reg_dcache_mode_gp  = cfg_addr_width_p'('h0043);
    localparam logic [cfg_addr_width_p-1:0] bp_cfg_reg_cce_mode_gp     = cfg_addr_width_p'('h0081);
    localparam logic [cfg_addr_width_p-1:0] bp_cfg_mem_base_cce_ucode_gp = cfg_addr_width_p'('h8000);
    localparam logic [cfg_addr_width_p-1:0] ucode_last_lp =
        cfg_addr_width_p'(int'(bp_cfg_mem_base_cce_ucode_gp) + (2 ** inst_ram_addr_width_p) - 1);

    localparam logic [1:0] e_lce_mode_uncached = 2'd0;
    localparam logic       e_cce_mode_uncached = 1'b0;

`ifdef BP_CFG_MMIO_ERR_EN
    localparam logic [dword_width_p-1:0] bad_data_lp = '1;
`else
    localparam logic [dword_width_p-1:0] bad_data_lp = '0;
`endif

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    typedef enum logic [1:0] {
        e_ready    = 2'd0,
        e_ucode_rd = 2'd1,
        e_resp     = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic                       reset_q;
    logic                       freeze_q;
    logic [1:0]                 icache_mode_q;
    logic [1:0]                 dcache_mode_q;
    logic                       cce_mode_q;
    logic [vaddr_width_p-1:0]   npc_q;
    logic                       npc_w_v_q;
    logic [hdr_width_lp-1:0]    resp_hdr_q;
    logic [dword_width_p-1:0]   resp_data_q;
`ifdef BP_CFG_MMIO_ERR_EN
    logic                       err_q;
`endif

    // ---------------------------------------------------------------------
    // Command decode
    // ---------------------------------------------------------------------
    logic [1:0]                  cmd_type;
    logic [cfg_addr_width_p-1:0] cmd_offset;
    logic [dev_width_lp-1:0]     cmd_dev;
    logic [cce_id_width_p-1:0]   cmd_cce;
    logic                        cmd_nonlocal;

    assign cmd_type     = io.io_cmd[type_lsb_lp +: 2];
    assign cmd_offset   = io.io_cmd[addr_lsb_lp +: cfg_addr_width_p];
    assign cmd_dev      = io.io_cmd[dev_lsb_lp +: dev_width_lp];
    assign cmd_cce      = io.io_cmd[cce_lsb_lp +: cce_id_width_p];
    assign cmd_nonlocal = io.io_cmd[nonlocal_bit_lp];

    logic is_rd, is_wr, mapped, ucode_hit, reg_hit, cmd_good;
    logic cmd_ready, resp_v, accept, reg_wr;
    logic [dword_width_p-1:0] reg_rd_data;
    logic [dword_width_p-1:0] resp_data_d;

    assign is_rd     = (cmd_type == e_cce_io_rd);
    assign is_wr     = (cmd_type == e_cce_io_wr);
    assign mapped    = ~cmd_nonlocal & (cmd_cce == cce_id_i) & (cmd_dev == cfg_dev_gp);
    assign ucode_hit = (cmd_offset >= bp_cfg_mem_base_cce_ucode_gp) && (cmd_offset <= ucode_last_lp);

    // Register file read mux; reg_hit doubles as the "known offset" flag.
    always_comb begin
        reg_hit     = 1'b1;
        reg_rd_data = '0;
        case (cmd_offset)
            bp_cfg_reg_reset_gp:       reg_rd_data = dword_width_p'(reset_q);
            bp_cfg_reg_freeze_gp:      reg_rd_data = dword_width_p'(freeze_q);
            bp_cfg_reg_icache_mode_gp: reg_rd_data = dword_width_p'(icache_mode_q);
            bp_cfg_reg_dcache_mode_gp: reg_rd_data = dword_width_p'(dcache_mode_q);
            bp_cfg_reg_cce_mode_gp:    reg_rd_data = dword_width_p'(cce_mode_q);
            bp_cfg_reg_npc_gp:         reg_rd_data = dword_width_p'(npc_q);
            default:                   reg_hit     = 1'b0;
        endcase
    end

    // A command with an unknown msg_type is treated like an unknown offset:
    // no side effect, error-fill data.
    assign cmd_good = mapped & (is_rd | is_wr) & (reg_hit | ucode_hit);

    // Data captured into the response at accept. Ucode reads overwrite it
    // one cycle later with the RAM output.
    always_comb begin
        resp_data_d = '0;
        if (!cmd_good) begin
            resp_data_d = bad_data_lp;
        end else if (is_rd && reg_hit) begin
            resp_data_d = reg_rd_data;
        end
    end

    // ---------------------------------------------------------------------
    // FSM: next state and handshake outputs
    // ---------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        cmd_ready = 1'b0;
        resp_v    = 1'b0;
        case (state_q)
            e_ready: begin
                // Held low during reset so nothing is taken while the
                // registers are being cleared.
                cmd_ready = ~reset_i;
                if (io.io_cmd_v && cmd_ready) begin
                    state_d = (cmd_good && ucode_hit && is_rd) ? e_ucode_rd : e_resp;
                end
            end
            e_ucode_rd: begin
                state_d = e_resp;
            end
            e_resp: begin
                resp_v = 1'b1;
                if (io.io_resp_yumi) begin
                    state_d = e_ready;
                end
            end
            default: begin
                state_d = e_ready;
            end
        endcase
    end

    assign accept = io.io_cmd_v & cmd_ready;
    assign reg_wr = accept & cmd_good & is_wr & reg_hit;

    // ---------------------------------------------------------------------
    // Sequential state
    // ---------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q       <= e_ready;
            reset_q       <= 1'b1;
            freeze_q      <= 1'b1;
            icache_mode_q <= e_lce_mode_uncached;
            dcache_mode_q <= e_lce_mode_uncached;
            cce_mode_q    <= e_cce_mode_uncached;
            npc_q         <= '0;
            npc_w_v_q     <= 1'b0;
            resp_hdr_q    <= '0;
            resp_data_q   <= '0;
`ifdef BP_CFG_MMIO_ERR_EN
            err_q         <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            npc_w_v_q <= 1'b0;

            if (accept) begin
                // msg_type, addr, size and payload echo straight back.
                resp_hdr_q  <= io.io_cmd[msg_width_lp-1:dword_width_p];
                resp_data_q <= resp_data_d;
`ifdef BP_CFG_MMIO_ERR_EN
                if (!cmd_good) begin
                    err_q <= 1'b1;
                end
`endif
            end

            if (reg_wr) begin
                case (cmd_offset)
                    bp_cfg_reg_reset_gp:       reset_q       <= io.io_cmd[data_lsb_lp];
                    bp_cfg_reg_freeze_gp:      freeze_q      <= io.io_cmd[data_lsb_lp];
                    bp_cfg_reg_icache_mode_gp: icache_mode_q <= io.io_cmd[data_lsb_lp +: 2];
                    bp_cfg_reg_dcache_mode_gp: dcache_mode_q <= io.io_cmd[data_lsb_lp +: 2];
                    bp_cfg_reg_cce_mode_gp:    cce_mode_q    <= io.io_cmd[data_lsb_lp];
                    bp_cfg_reg_npc_gp: begin
                        npc_q     <= io.io_cmd[data_lsb_lp +: vaddr_width_p];
                        npc_w_v_q <= 1'b1;
                    end
                    default: ;
                endcase
            end

            // RAM read data is valid the cycle after the read strobe.
            if (state_q == e_ucode_rd) begin
                resp_data_q <= dword_width_p'(cce_ucode_data_i);
            end
        end
    end

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    assign io.io_cmd_ready = cmd_ready;
    assign io.io_resp_v    = resp_v;
    assign io.io_resp      = {resp_hdr_q, resp_data_q};

    assign reset_o       = reset_q;
    assign freeze_o      = freeze_q;
    assign icache_mode_o = icache_mode_q;
    assign dcache_mode_o = dcache_mode_q;
    assign cce_mode_o    = cce_mode_q;
    assign npc_o         = npc_q;
    assign npc_w_v_o     = npc_w_v_q;

    assign cce_ucode_v_o    = accept & cmd_good & ucode_hit;
    assign cce_ucode_w_o    = accept & cmd_good & ucode_hit & is_wr;
    assign cce_ucode_addr_o = inst_ram_addr_width_p'(cmd_offset - bp_cfg_mem_base_cce_ucode_gp);
    assign cce_ucode_data_o = io.io_cmd[data_lsb_lp +: cce_inst_width_p];

`ifdef BP_CFG_MMIO_ERR_EN
    assign err_o = err_q;
`endif

    assign fsm_state_o = state_q;

endmodule

// File: tb/tb_bp_cfg_mmio_responder.sv
`timescale 1ns/1ps
module tb_bp_cfg_mmio_responder;

  localparam int PADDR = 40;
  localparam int DWORD = 64;
  localparam int LCEW  = 4;
  localparam int VADDR = 39;
  localparam int IAW   = 8;
  localparam int INSTW = 48;
  localparam int MSGW  = 2 + PADDR + 2 + LCEW + DWORD;

  localparam logic [1:0]  T_RD = 2'd0;
  localparam logic [1:0]  T_WR = 2'd1;
  localparam logic [3:0]  CFG_DEV = 4'd2;
  localparam logic [3:0]  MY_CCE  = 4'd3;
  localparam logic [15:0] OFF_RESET  = 16'h0001;
  localparam logic [15:0] OFF_FREEZE = 16'h0002;
  localparam logic [15:0] OFF_NPC    = 16'h0010;
  localparam logic [15:0] OFF_IMODE  = 16'h0022;
  localparam logic [15:0] OFF_DMODE  = 16'h0043;
  localparam logic [15:0] OFF_CMODE  = 16'h0081;
  localparam logic [15:0] UC_BASE    = 16'h8000;
`ifdef BP_CFG_MMIO_ERR_EN
  localparam logic [63:0] BAD_DATA = '1;
`else
  localparam logic [63:0] BAD_DATA = '0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_i = 1'b1;
  always #5 clk = ~clk;

  bp_cfg_mmio_responder_if #(.msg_width_p(MSGW)) io_if ();

  logic             reset_o, freeze_o, cce_mode_o, npc_w_v_o;
  logic [1:0]       icache_mode_o, dcache_mode_o, fsm_state_o;
  logic [VADDR-1:0] npc_o;
  logic             cce_ucode_v_o, cce_ucode_w_o;
  logic [IAW-1:0]   cce_ucode_addr_o;
  logic [INSTW-1:0] cce_ucode_data_o;
  logic [INSTW-1:0] ucode_rdata;
`ifdef BP_CFG_MMIO_ERR_EN
  logic             err_o;
`endif

  bp_cfg_mmio_responder dut (
    .clk_i            (clk),
    .reset_i          (reset_i),
    .cce_id_i         (MY_CCE),
    .io               (io_if),
    .reset_o          (reset_o),
    .freeze_o         (freeze_o),
    .icache_mode_o    (icache_mode_o),
    .dcache_mode_o    (dcache_mode_o),
    .cce_mode_o       (cce_mode_o),
    .npc_o            (npc_o),
    .npc_w_v_o        (npc_w_v_o),
    .cce_ucode_v_o    (cce_ucode_v_o),
    .cce_ucode_w_o    (cce_ucode_w_o),
    .cce_ucode_addr_o (cce_ucode_addr_o),
    .cce_ucode_data_o (cce_ucode_data_o),
    .cce_ucode_data_i (ucode_rdata),
`ifdef BP_CFG_MMIO_ERR_EN
    .err_o            (err_o),
`endif
    .fsm_state_o      (fsm_state_o)
  );

  // Bench-side ucode RAM (environment, not the reference model).
  logic [INSTW-1:0] ram [256] = '{default: '0};
  always @(posedge clk) begin
    if (cce_ucode_v_o && cce_ucode_w_o) ram[cce_ucode_addr_o] <= cce_ucode_data_o;
    if (cce_ucode_v_o && !cce_ucode_w_o) ucode_rdata <= ram[cce_ucode_addr_o];
  end

  // ---------------- scoreboard / model ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  logic             m_reset, m_freeze, m_cmode, m_err;
  logic [1:0]       m_imode, m_dmode;
  logic [VADDR-1:0] m_npc;
  logic [INSTW-1:0] m_ucode [256] = '{default: '0};
  logic             exp_npc_pulse = 1'b0;
  logic             chk_en = 1'b0;
  int               npc_pulse_cnt = 0;
  int               ucode_wr_cnt = 0;
  logic [MSGW-1:0]  last_resp;
  logic [MSGW-1:0]  exp_q [$];

  task automatic model_reset();
    m_reset = 1'b1; m_freeze = 1'b1; m_cmode = 1'b0; m_err = 1'b0;
    m_imode = 2'd0; m_dmode = 2'd0; m_npc = '0; exp_npc_pulse = 1'b0;
  endtask

  function automatic bit is_good(input logic [1:0] typ, input logic [39:0] addr);
    logic [15:0] off;
    bit known;
    off = addr[15:0];
    known = (off inside {OFF_RESET, OFF_FREEZE, OFF_NPC, OFF_IMODE, OFF_DMODE, OFF_CMODE})
            || (off >= UC_BASE && off < UC_BASE + 16'd256);
    return !addr[24] && addr[23:20] == MY_CCE && addr[19:16] == CFG_DEV
           && (typ == T_RD || typ == T_WR) && known;
  endfunction

  function automatic bit is_uc(input logic [39:0] addr);
    return addr[15:0] >= UC_BASE && addr[15:0] < UC_BASE + 16'd256;
  endfunction

  function automatic logic [63:0] model_data(input logic [1:0] typ, input logic [39:0] addr);
    logic [15:0] off;
    off = addr[15:0];
    if (!is_good(typ, addr)) return BAD_DATA;
    if (typ == T_WR) return 64'd0;
    if (is_uc(addr)) return {16'd0, m_ucode[off - UC_BASE]};
    case (off)
      OFF_RESET:  return {63'd0, m_reset};
      OFF_FREEZE: return {63'd0, m_freeze};
      OFF_IMODE:  return {62'd0, m_imode};
      OFF_DMODE:  return {62'd0, m_dmode};
      OFF_CMODE:  return {63'd0, m_cmode};
      default:    return {25'd0, m_npc};
    endcase
  endfunction

  task automatic model_apply(input logic [1:0] typ, input logic [39:0] addr, input logic [63:0] data);
    logic [15:0] off;
    off = addr[15:0];
    if (!is_good(typ, addr)) begin
`ifdef BP_CFG_MMIO_ERR_EN
      m_err = 1'b1;
`endif
      return;
    end
    if (typ != T_WR) return;
    if (is_uc(addr)) m_ucode[off - UC_BASE] = data[INSTW-1:0];
    else case (off)
      OFF_RESET:  m_reset  = data[0];
      OFF_FREEZE: m_freeze = data[0];
      OFF_IMODE:  m_imode  = data[1:0];
      OFF_DMODE:  m_dmode  = data[1:0];
      OFF_CMODE:  m_cmode  = data[0];
      default: begin m_npc = data[VADDR-1:0]; exp_npc_pulse = 1'b1; end
    endcase
  endtask

  // Per-cycle compare of the configuration outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("reset_o", reset_o, m_reset);
      chk("freeze_o", freeze_o, m_freeze);
      chk("icache_mode_o", icache_mode_o, m_imode);
      chk("dcache_mode_o", dcache_mode_o, m_dmode);
      chk("cce_mode_o", cce_mode_o, m_cmode);
      chk("npc_o", npc_o, m_npc);
      chk("npc_w_v_o", npc_w_v_o, exp_npc_pulse);
`ifdef BP_CFG_MMIO_ERR_EN
      chk("err_o", err_o, m_err);
`endif
      if (!io_if.io_cmd_v) chk("ucode_v_idle", cce_ucode_v_o, 1'b0);
      if (reset_i) chk("ready_in_reset", io_if.io_cmd_ready, 1'b0);
      if (npc_w_v_o) npc_pulse_cnt++;
      if (cce_ucode_v_o && cce_ucode_w_o) ucode_wr_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk); #1;
    exp_npc_pulse = 1'b0;
  endtask

  function automatic logic [39:0] mk_addr(input bit nl, input logic [3:0] cce,
                                          input logic [3:0] dev, input logic [15:0] off);
    logic [14:0] hi;
    hi = 15'($urandom);
    return {hi, nl, cce, dev, off};
  endfunction

  // One full transaction; returns at a negedge. With leave_pending the
  // response is left un-consumed.
  task automatic txn(input logic [1:0] typ, input logic [39:0] addr, input logic [63:0] data,
                     input int yumi_delay, input bit leave_pending);
    logic [1:0] sz;
    logic [3:0] pl;
    logic [MSGW-1:0] eresp;
    int elat, lat, n;
    bit uc;
    sz = 2'($urandom_range(0, 3));
    pl = 4'($urandom_range(0, 15));
    uc = is_good(typ, addr) && is_uc(addr);
    elat = (uc && typ == T_RD) ? 2 : 1;
    tick();
    io_if.io_cmd = {typ, addr, sz, pl, data};
    io_if.io_cmd_v = 1'b1;
    @(negedge clk);
    n = 0;
    while (!io_if.io_cmd_ready && n < 20) begin tick(); @(negedge clk); n++; end
    chk("accept_ready", io_if.io_cmd_ready, 1'b1);
    if (!io_if.io_cmd_ready) begin io_if.io_cmd_v = 1'b0; return; end
    chk("ucode_v", cce_ucode_v_o, uc);
    if (uc) begin
      chk("ucode_w", cce_ucode_w_o, typ == T_WR);
      chk("ucode_addr", cce_ucode_addr_o, 8'(addr[15:0] - UC_BASE));
      if (typ == T_WR) chk("ucode_wdata", cce_ucode_data_o, data[INSTW-1:0]);
    end
    @(posedge clk); #1;
    io_if.io_cmd_v = 1'b0;
    exp_npc_pulse = 1'b0;
    eresp = {typ, addr, sz, pl, model_data(typ, addr)};
    model_apply(typ, addr, data);
    exp_q.push_back(eresp);
    lat = 1;
    @(negedge clk);
    while (!io_if.io_resp_v && lat < 8) begin tick(); lat++; @(negedge clk); end
    chk("resp_latency", lat, elat);
    chk("resp_v", io_if.io_resp_v, 1'b1);
    eresp = exp_q.pop_front();
    chk("resp_msg", io_if.io_resp, eresp);
    chk("ready_busy", io_if.io_cmd_ready, 1'b0);
    last_resp = io_if.io_resp;
    if (leave_pending) return;
    for (int i = 0; i < yumi_delay; i++) begin
      tick(); @(negedge clk);
      chk("resp_hold_v", io_if.io_resp_v, 1'b1);
      chk("resp_hold", io_if.io_resp, eresp);
      chk("ready_hold", io_if.io_cmd_ready, 1'b0);
    end
    tick();
    io_if.io_resp_yumi = 1'b1;
    @(negedge clk);
    chk("ready_at_yumi", io_if.io_cmd_ready, 1'b0);
    tick();
    io_if.io_resp_yumi = 1'b0;
    @(negedge clk);
    chk("ready_after_yumi", io_if.io_cmd_ready, 1'b1);
    chk("resp_v_after_yumi", io_if.io_resp_v, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int pcnt, ucnt, kind;
    logic [15:0] off;
    logic [15:0] regs [6];
    regs = '{OFF_RESET, OFF_FREEZE, OFF_NPC, OFF_IMODE, OFF_DMODE, OFF_CMODE};
    io_if.io_cmd = '0;
    io_if.io_cmd_v = 1'b0;
    io_if.io_resp_yumi = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_resp_v", io_if.io_resp_v, 1'b0);
    tick();
    reset_i = 1'b0;
    @(negedge clk);
    // Literal reset pins.
    chk("lit_reset_o", reset_o, 1'b1);
    chk("lit_freeze_o", freeze_o, 1'b1);
    chk("lit_imode", icache_mode_o, 2'd0);
    chk("lit_cmode", cce_mode_o, 1'b0);
    chk("lit_npc", npc_o, 0);
    chk("lit_ready", io_if.io_cmd_ready, 1'b1);

    // Freeze write then read.
    txn(T_WR, mk_addr(1'b0, MY_CCE, CFG_DEV, OFF_FREEZE), 64'h0, 0, 1'b0);
    chk("lit_freeze_now0", freeze_o, 1'b0);
    txn(T_RD, mk_addr(1'b0, MY_CCE, CFG_DEV, OFF_FREEZE), 64'hdead, 1, 1'b0);
    chk("lit_freeze_rd_data", last_resp[63:0], 64'h0);
    chk("lit_freeze_rd_type", last_resp[MSGW-1 -: 2], T_RD);

    // Ucode writes 0..3 then read offset 2.
    ucnt = ucode_wr_cnt;
    for (int i = 0; i < 4; i++)
      txn(T_WR, mk_addr(1'b0, MY_CCE, CFG_DEV, UC_BASE + 16'(i)), 64'h11 + 64'(i), 0, 1'b0);
    chk("lit_ucode_wr_strobes", ucode_wr_cnt - ucnt, 4);
    txn(T_RD, mk_addr(1'b0, MY_CCE, CFG_DEV, UC_BASE + 16'd2), 64'h0, 0, 1'b0);
    chk("lit_ucode_rd_data", last_resp[63:0], 64'h13);

    // NPC write with a slow consumer.
    pcnt = npc_pulse_cnt;
    txn(T_WR, mk_addr(1'b0, MY_CCE, CFG_DEV, OFF_NPC), 64'h8000_0000, 5, 1'b0);
    chk("lit_npc_pulses", npc_pulse_cnt - pcnt, 1);
    chk("lit_npc_val", npc_o, 39'h80000000);

    // Wrong CCE id: no side effect.
    txn(T_WR, mk_addr(1'b0, 4'd5, CFG_DEV, OFF_FREEZE), 64'h1, 0, 1'b0);
    chk("lit_unmapped_freeze", freeze_o, 1'b0);
    chk("lit_unmapped_data", last_resp[63:0], BAD_DATA);

    // Randomized traffic.
    for (int t = 0; t < 120; t++) begin
      kind = $urandom_range(0, 7);
      case (kind)
        0: txn(T_WR, mk_addr(1'b0, MY_CCE, CFG_DEV, regs[$urandom_range(0, 5)]),
               {$urandom, $urandom}, $urandom_range(0, 3), 1'b0);
        1: txn(T_RD, mk_addr(1'b0, MY_CCE, CFG_DEV, regs[$urandom_range(0, 5)]),
               {$urandom, $urandom}, $urandom_range(0, 3), 1'b0);
        2: txn(T_WR, mk_addr(1'b0, MY_CCE, CFG_DEV, UC_BASE + 16'($urandom_range(0, 255))),
               {$urandom, $urandom}, $urandom_range(0, 2), 1'b0);
        3, 4: txn(T_RD, mk_addr(1'b0, MY_CCE, CFG_DEV, UC_BASE + 16'($urandom_range(0, 255))),
               {$urandom, $urandom}, $urandom_range(0, 2), 1'b0);
        5: begin
          off = ($urandom_range(0, 1) == 1) ? regs[$urandom_range(0, 5)]
                                            : UC_BASE + 16'($urandom_range(0, 255));
          case ($urandom_range(0, 2))
            0: txn(2'($urandom_range(0, 1)), mk_addr(1'b1, MY_CCE, CFG_DEV, off), {$urandom, $urandom}, 0, 1'b0);
            1: txn(2'($urandom_range(0, 1)), mk_addr(1'b0, MY_CCE ^ 4'd1, CFG_DEV, off), {$urandom, $urandom}, 0, 1'b0);
            default: txn(2'($urandom_range(0, 1)), mk_addr(1'b0, MY_CCE, 4'd7, off), {$urandom, $urandom}, 0, 1'b0);
          endcase
        end
        6: txn(2'($urandom_range(0, 1)), mk_addr(1'b0, MY_CCE, CFG_DEV, 16'h0100 + 16'($urandom_range(0, 255))),
               {$urandom, $urandom}, 1, 1'b0);
        default: txn(2'($urandom_range(2, 3)), mk_addr(1'b0, MY_CCE, CFG_DEV, regs[$urandom_range(0, 5)]),
               {$urandom, $urandom}, 0, 1'b0);
      endcase
    end

    // Reset while a response is pending.
    txn(T_WR, mk_addr(1'b0, MY_CCE, CFG_DEV, OFF_RESET), 64'h0, 0, 1'b1);
    tick();
    reset_i = 1'b1;
    @(posedge clk); #1;
    model_reset();
    @(negedge clk);
    chk("lit_rst_resp_v", io_if.io_resp_v, 1'b0);
    chk("lit_rst_reset_o", reset_o, 1'b1);
    chk("lit_rst_freeze_o", freeze_o, 1'b1);
    tick();
    reset_i = 1'b0;
    @(negedge clk);
    chk("rst_ready_after", io_if.io_cmd_ready, 1'b1);
    txn(T_RD, mk_addr(1'b0, MY_CCE, CFG_DEV, OFF_NPC), 64'h0, 0, 1'b0);
    chk("lit_npc_after_rst", last_resp[63:0], 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
